// File: rtl/fetch_pkg.sv
`default_nettype none
// ==== fetch_pkg : fetch-stage state encoding and opcode helper (rev 1.0) ====
package fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2,
      ST_FAULT  = 2'd3
   } fetch_state_t;

   localparam int                    OPCODE_WIDTH = 5;
   localparam logic [OPCODE_WIDTH-1:0] HALT_OPCODE = 5'b11111;

   // Word is passed zero-extended to 64 bits so one helper serves any instruction width.
   function automatic logic [15:0] opcode_of(input logic [63:0] word, input int iw, input int ow);
      return 16'((word >> (iw - ow)) & ((64'd1 << ow) - 64'd1));
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_reg.sv
`default_nettype none
// ==== fetch_stage_reg : valid/ready output register toward decode (rev 1.0) ====
module fetch_stage_reg #(
   parameter int DATA_WIDTH = 50
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_load,
   input  logic                  i_flush,
   input  logic                  i_accept,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic                  o_valid,
   output logic [DATA_WIDTH-1:0] o_data
);

   logic                  r_valid;
   logic [DATA_WIDTH-1:0] r_data;

   // Flush beats load beats accept; a load in the same cycle as an accept refills the slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_flush) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
      end else if (i_accept) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/fetch_controller.sv
`default_nettype none
// ==== fetch_controller : PC sequencer with halt/fault handling (rev 1.0) ====
module fetch_controller #(
   parameter int                       PC_WIDTH          = 18,
   parameter int                       INSTRUCTION_WIDTH = 32,
   parameter int                       MEMORY_SIZE       = 1024,
   parameter logic [PC_WIDTH-1:0]      RESET_PC          = '0,
   parameter int                       OPCODE_WIDTH      = fetch_pkg::OPCODE_WIDTH,
   parameter logic [OPCODE_WIDTH-1:0]  HALT_OPCODE       = fetch_pkg::HALT_OPCODE
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic                         redirect_valid,
   input  logic [PC_WIDTH-1:0]          redirect_pc,
   output logic [PC_WIDTH-1:0]          mem_pc,
   input  logic [INSTRUCTION_WIDTH-1:0] mem_instruction,
   output logic                         if_valid,
   input  logic                         if_ready,
   output logic [INSTRUCTION_WIDTH-1:0] if_instruction,
   output logic [PC_WIDTH-1:0]          if_pc,
   output logic                         halted,
   output logic                         pc_fault
);
   import fetch_pkg::*;

   fetch_state_t                          r_state;
   logic [PC_WIDTH-1:0]                   r_pc;
   logic                                  r_halted;
   logic                                  r_fault;
   logic                                  w_in_range;
   logic                                  w_slot_free;
   logic                                  w_accept;
   logic                                  w_capture;
   logic                                  w_fault_due;
   logic                                  w_is_halt;
   logic [INSTRUCTION_WIDTH+PC_WIDTH-1:0] w_stage_data;

   // One extra bit lets MEMORY_SIZE == 2**PC_WIDTH compare as always in range.
   assign w_in_range  = ({1'b0, r_pc} < (PC_WIDTH+1)'(MEMORY_SIZE));
   assign w_slot_free = !if_valid || if_ready;
   assign w_accept    = if_valid && if_ready;
   assign w_capture   = (r_state == ST_RUN) && !redirect_valid && w_in_range && w_slot_free;
   assign w_fault_due = (r_state == ST_RUN) && !redirect_valid && !w_in_range && w_slot_free;
   assign w_is_halt   = (opcode_of(64'(mem_instruction), INSTRUCTION_WIDTH, OPCODE_WIDTH)
                         == 16'(HALT_OPCODE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_pc     <= RESET_PC;
         r_halted <= 1'b0;
         r_fault  <= 1'b0;
      end else if (redirect_valid) begin
         r_pc <= redirect_pc;
         case (r_state)
            ST_FAULT: begin
               r_state <= ST_IDLE;
               r_fault <= 1'b0;
            end
            ST_IDLE, ST_HALTED: begin
               if (start) begin
                  r_state  <= ST_RUN;
                  r_halted <= 1'b0;
               end
            end
            default: ;
         endcase
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) r_state <= ST_RUN;
            end
            ST_HALTED: begin
               if (start) begin
                  r_state  <= ST_RUN;
                  r_halted <= 1'b0;
               end
            end
            ST_RUN: begin
               if (w_capture) begin
                  r_pc <= r_pc + PC_WIDTH'(1);
                  if (w_is_halt) begin
                     r_state  <= ST_HALTED;
                     r_halted <= 1'b1;
                  end
               end else if (w_fault_due) begin
                  r_state <= ST_FAULT;
                  r_fault <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   fetch_stage_reg #(
      .DATA_WIDTH (INSTRUCTION_WIDTH + PC_WIDTH)
   ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   (w_capture),
      .i_flush  (redirect_valid),
      .i_accept (w_accept),
      .i_data   ({mem_instruction, r_pc}),
      .o_valid  (if_valid),
      .o_data   (w_stage_data)
   );

   assign mem_pc         = r_pc;
   assign if_instruction = w_stage_data[PC_WIDTH +: INSTRUCTION_WIDTH];
   assign if_pc          = w_stage_data[PC_WIDTH-1:0];
   assign halted         = r_halted;
   assign pc_fault       = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_fetch_controller.sv
`default_nettype none
// ==== tb_fetch_controller : table and scoreboard bench for fetch_controller (rev 1.0) ====
module tb_fetch_controller;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [17:0] redirect_pc = '0;
   logic        if_ready = 1'b0;
   logic        halt_en = 1'b0;
   logic        sb_en = 1'b1;

   logic [17:0] m_pc, ifp, f_mpc, f_ifp;
   logic [31:0] m_ins, ifi, f_mins, f_ifi;
   logic        v, halted, fault, f_v, f_halted, f_fault;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [17:0] a, input logic h);
      return (h && a == 18'd3) ? 32'hF800_0003 : {5'b00001, 9'd0, a};
   endfunction

   assign m_ins  = mem_word(m_pc, halt_en);
   assign f_mins = mem_word(f_mpc, halt_en);

   fetch_controller u_dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .mem_pc(m_pc), .mem_instruction(m_ins),
      .if_valid(v), .if_ready(if_ready), .if_instruction(ifi), .if_pc(ifp),
      .halted(halted), .pc_fault(fault)
   );

   fetch_controller #(.MEMORY_SIZE(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .mem_pc(f_mpc), .mem_instruction(f_mins),
      .if_valid(f_v), .if_ready(if_ready), .if_instruction(f_ifi), .if_pc(f_ifp),
      .halted(f_halted), .pc_fault(f_fault)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic [17:0] pc;
      logic [31:0] ins;
   } exp_t;
   exp_t sbq[$];

   task automatic sb_push(input logic [17:0] a);
      sbq.push_back('{a, mem_word(a, halt_en)});
   endtask

   // A handshake completes at the next rising edge when valid and ready are both seen here.
   always @(negedge clk) begin
      if (rst_n && sb_en && v && if_ready) begin
         if (sbq.size() == 0) begin
            chk("sb_unexpected_accept_pc", {46'd0, ifp}, 64'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("sb_pc", {46'd0, ifp}, {46'd0, e.pc});
            chk("sb_instr", {32'd0, ifi}, {32'd0, e.ins});
         end
      end
   end

   typedef struct {
      logic        st, rdy, rv;
      logic [17:0] rpc;
      logic        push, ev;
      logic [17:0] eifpc, empc;
   } vec_t;
   vec_t tv[$];

   task automatic add(input logic st, rdy, rv, input logic [17:0] rpc,
                      input logic push, ev, input logic [17:0] eifpc, empc);
      tv.push_back('{st, rdy, rv, rpc, push, ev, eifpc, empc});
   endtask

   task automatic cyc(input logic st, rdy, rv, input logic [17:0] rpc);
      start = st; if_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //   st rdy rv rpc     push ev eifpc  empc
      add(1, 1, 0, 18'h0,  0, 0, 18'h0,  18'h0);
      add(0, 1, 0, 18'h0,  1, 1, 18'h0,  18'h1);
      add(0, 1, 0, 18'h0,  1, 1, 18'h1,  18'h2);
      add(0, 0, 0, 18'h0,  0, 1, 18'h1,  18'h2);
      add(0, 0, 0, 18'h0,  0, 1, 18'h1,  18'h2);
      add(0, 0, 0, 18'h0,  0, 1, 18'h1,  18'h2);
      add(0, 1, 0, 18'h0,  1, 1, 18'h2,  18'h3);
      add(0, 1, 0, 18'h0,  1, 1, 18'h3,  18'h4);
      add(0, 1, 0, 18'h0,  1, 1, 18'h4,  18'h5);
      add(0, 1, 0, 18'h0,  0, 1, 18'h5,  18'h6);
      add(0, 0, 1, 18'h40, 0, 0, 18'h0,  18'h40);
      add(0, 0, 0, 18'h0,  1, 1, 18'h40, 18'h41);
      add(0, 1, 0, 18'h0,  1, 1, 18'h41, 18'h42);
      add(0, 1, 1, 18'h0,  0, 0, 18'h0,  18'h0);
      add(0, 1, 0, 18'h0,  1, 1, 18'h0,  18'h1);
      add(0, 1, 1, 18'h0,  0, 0, 18'h0,  18'h0);

      #23;
      chk("rst_valid", v, 0);
      chk("rst_if_pc", ifp, 0);
      chk("rst_if_instr", ifi, 0);
      chk("rst_mem_pc", m_pc, 0);
      chk("rst_flags", {halted, fault}, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      foreach (tv[i]) begin
         if (tv[i].push) sb_push(tv[i].eifpc);
         cyc(tv[i].st, tv[i].rdy, tv[i].rv, tv[i].rpc);
         chk($sformatf("vec%0d_valid", i), v, tv[i].ev);
         chk($sformatf("vec%0d_mem_pc", i), m_pc, tv[i].empc);
         if (tv[i].ev) begin
            chk($sformatf("vec%0d_if_pc", i), ifp, tv[i].eifpc);
            chk($sformatf("vec%0d_if_instr", i), ifi, mem_word(tv[i].eifpc, halt_en));
         end
         chk($sformatf("vec%0d_flags", i), {halted, fault}, 0);
      end

      // Halt word at address 3, then resume with start.
      halt_en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         sb_push(18'(k));
         cyc(0, 1, 0, 18'h0);
      end
      chk("halt_valid", v, 1);
      chk("halt_if_pc", ifp, 3);
      chk("halt_if_instr", ifi, 32'hF800_0003);
      chk("halt_halted", halted, 1);
      chk("halt_mem_pc", m_pc, 4);
      cyc(0, 1, 0, 18'h0);
      chk("halt_drain_valid", v, 0);
      chk("halt_hold_halted", halted, 1);
      cyc(0, 1, 0, 18'h0);
      chk("halt_no_capture", v, 0);
      chk("halt_pc_hold", m_pc, 4);
      cyc(1, 1, 0, 18'h0);
      chk("resume_halted_clr", halted, 0);
      chk("resume_no_capture_yet", v, 0);
      sb_push(18'd4);
      cyc(0, 0, 0, 18'h0);
      chk("resume_valid", v, 1);
      chk("resume_if_pc", ifp, 4);
      cyc(0, 1, 1, 18'h10);
      chk("redir_ready_flush", v, 0);
      chk("redir_mem_pc", m_pc, 18'h10);
      cyc(0, 0, 0, 18'h0);
      chk("pre_reset_valid", v, 1);
      chk("sb_drained", sbq.size(), 0);

      // Asynchronous reset mid-cycle with a pending word.
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", v, 0);
      chk("arst_if_pc", ifp, 0);
      chk("arst_if_instr", ifi, 0);
      chk("arst_mem_pc", m_pc, 0);
      chk("arst_flags", {halted, fault}, 0);
      halt_en = 1'b0;
      sb_en = 1'b0;
      @(posedge clk); #3;
      rst_n = 1'b1;

      // Small memory: run off the end, fault, recover via redirect.
      cyc(1, 1, 0, 18'h0);
      for (int k = 0; k < 8; k++) cyc(0, 1, 0, 18'h0);
      chk("m8_last_valid", f_v, 1);
      chk("m8_last_if_pc", f_ifp, 7);
      chk("m8_last_instr", f_ifi, mem_word(18'd7, 1'b0));
      chk("m8_no_fault_yet", f_fault, 0);
      cyc(0, 1, 0, 18'h0);
      chk("m8_fault", f_fault, 1);
      chk("m8_fault_no_capture", f_v, 0);
      cyc(0, 1, 0, 18'h0);
      chk("m8_fault_hold", f_fault, 1);
      chk("m8_fault_pc", f_mpc, 8);
      cyc(0, 0, 1, 18'h0);
      chk("m8_redir_fault_clr", f_fault, 0);
      chk("m8_redir_pc", f_mpc, 0);
      chk("m8_redir_idle_valid", f_v, 0);
      cyc(1, 1, 0, 18'h0);
      chk("m8_start_valid", f_v, 0);
      cyc(0, 1, 0, 18'h0);
      chk("m8_refetch_valid", f_v, 1);
      chk("m8_refetch_if_pc", f_ifp, 0);
      chk("m8_refetch_instr", f_ifi, mem_word(18'd0, 1'b0));
      chk("m8_halted", f_halted, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
